// File: rtl/join_recv_pack_xc.sv
// Multi-channel four-phase link receiver with word packing, frame-length
// driven tlast, idle-timeout flush of partial beats and a per-channel
// first-word-fall-through FIFO feeding an AXI-Stream master.
//
// Handshake FSM (one per channel):
//   state      | meaning
//   S_IDLE     | waiting for synchronized request and room in the packer
//   S_CAPTURE  | din is stable; latch it into the current packer slot
//   S_WAIT_LOW | acknowledge held high until request returns low
module join_recv_pack_xc #(
    parameter int CHANNEL    = 4,
    parameter int DIN_WIDTH  = 32,
    parameter int PACK       = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                                  m_axis_aclk,
    input  logic                                  m_axis_areset,
    input  logic [CHANNEL-1:0]                    request,
    input  logic [CHANNEL*DIN_WIDTH-1:0]          din,
    output logic [CHANNEL-1:0]                    acknowledge,
    input  logic [CHANNEL*16-1:0]                 frame_len,
    input  logic [CHANNEL-1:0]                    m_axis_tready,
    output logic [CHANNEL*PACK*DIN_WIDTH-1:0]     m_axis_tdata,
    output logic [CHANNEL*PACK*DIN_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [CHANNEL-1:0]                    m_axis_tlast,
    output logic [CHANNEL-1:0]                    m_axis_tvalid,
    output logic [CHANNEL*16-1:0]                 frame_cnt
);

    localparam int BEAT  = PACK * DIN_WIDTH;
    localparam int KEEP  = BEAT / 8;
    localparam int WKEEP = DIN_WIDTH / 8;
    localparam int IDXW  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = 1 + KEEP + BEAT;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW-1:0]   TO_LOAD  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(PACK - 1);
    localparam logic [AW:0]     FULL_C   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURE  = 2'd1,
        S_WAIT_LOW = 2'd2
    } state_t;

    for (genvar c = 0; c < CHANNEL; c++) begin : g_ch
        logic [DIN_WIDTH-1:0] din_c;
        logic [15:0]          len_in;

        logic                 req_meta_q;
        logic                 req_s_q;
        state_t               state_q;
        logic                 ack_q;
        logic [BEAT-1:0]      pack_q;
        logic [IDXW-1:0]      idx_q;
        logic                 pend_q;
        logic [TW-1:0]        idle_q;

        logic [15:0]          beat_cnt_q;
        logic [15:0]          len_q;
        logic [15:0]          frame_cnt_q;

        logic [EW-1:0]        mem_q [FIFO_DEPTH];
        logic [AW-1:0]        wr_ptr_q;
        logic [AW-1:0]        rd_ptr_q;
        logic [AW:0]          count_q;
        logic [AW:0]          count_d;

        logic                 fifo_full;
        logic                 fifo_empty;
        logic                 push;
        logic                 pop;
        logic                 accept;
        logic                 flush_req;
        logic                 len_hit;
        logic                 wr_last;
        logic [15:0]          eff_len;
        logic [KEEP-1:0]      part_keep;
        logic [KEEP-1:0]      wr_keep;
        logic [EW-1:0]        wr_entry;
        logic [EW-1:0]        rd_entry;

        assign din_c  = din[c*DIN_WIDTH +: DIN_WIDTH];
        assign len_in = frame_len[c*16 +: 16];

        // Two-flop synchronizer for the asynchronous request line
        always_ff @(posedge m_axis_aclk) begin
            if (m_axis_areset) begin
                req_meta_q <= 1'b0;
                req_s_q    <= 1'b0;
            end else begin
                req_meta_q <= request[c];
                req_s_q    <= req_meta_q;
            end
        end

        // Byte enables of a partial beat: only slots below idx hold words
        always_comb begin
            part_keep = '0;
            for (int k = 0; k < PACK; k++) begin
                if (k < int'(idx_q)) begin
                    part_keep[k*WKEEP +: WKEEP] = '1;
                end
            end
        end

        // FIFO write/read decisions and the entry written on a push
        always_comb begin
            fifo_full  = (count_q == FULL_C);
            fifo_empty = (count_q == '0);
            pop        = !fifo_empty && m_axis_tready[c];
            // CAPTURE reloads the idle timer, so it always wins over a flush
            flush_req  = (TIMEOUT != 0) && (idx_q != '0) && (idle_q == '0)
                         && (state_q != S_CAPTURE);
            push       = (pend_q || flush_req) && (!fifo_full || pop);
            accept     = !pend_q || !fifo_full;
            // frame_len is taken fresh on the first beat of every frame
            eff_len    = (beat_cnt_q == '0) ? len_in : len_q;
            len_hit    = (eff_len != '0) && (beat_cnt_q == eff_len - 16'd1);
            wr_last    = flush_req || len_hit;
            wr_keep    = pend_q ? {KEEP{1'b1}} : part_keep;
            wr_entry   = {wr_last, wr_keep, pack_q};
            count_d    = count_q;
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && pop) begin
                count_d = count_q - 1'b1;
            end
        end

        // Handshake FSM together with the packer and idle timer it owns
        always_ff @(posedge m_axis_aclk) begin
            if (m_axis_areset) begin
                state_q <= S_IDLE;
                ack_q   <= 1'b0;
                pack_q  <= '0;
                idx_q   <= '0;
                pend_q  <= 1'b0;
                idle_q  <= '0;
            end else begin
                if (push && pend_q) begin
                    pend_q <= 1'b0;
                end
                if (push && flush_req) begin
                    idx_q <= '0;
                end
                if (state_q != S_CAPTURE && idx_q != '0 && idle_q != '0) begin
                    idle_q <= idle_q - TW'(1);
                end
                case (state_q)
                    S_IDLE: begin
                        if (req_s_q && accept) begin
                            state_q <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        // A new beat starts clean so a later flush sees zeros
                        if (idx_q == '0) begin
                            pack_q <= BEAT'(din_c);
                        end else begin
                            pack_q[idx_q*DIN_WIDTH +: DIN_WIDTH] <= din_c;
                        end
                        if (idx_q == IDX_LAST) begin
                            idx_q  <= '0;
                            pend_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                        end
                        idle_q  <= TO_LOAD;
                        ack_q   <= 1'b1;
                        state_q <= S_WAIT_LOW;
                    end
                    S_WAIT_LOW: begin
                        if (!req_s_q) begin
                            ack_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        ack_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end

        // FIFO pointers plus frame bookkeeping on every beat written
        always_ff @(posedge m_axis_aclk) begin
            if (m_axis_areset) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                beat_cnt_q  <= '0;
                len_q       <= '0;
                frame_cnt_q <= '0;
            end else begin
                count_q <= count_d;
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    if (beat_cnt_q == '0) begin
                        len_q <= len_in;
                    end
                    if (wr_last) begin
                        beat_cnt_q  <= '0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end else if (eff_len != '0) begin
                        beat_cnt_q <= beat_cnt_q + 16'd1;
                    end
                end
            end
        end

        // Beat storage; contents are don't-care until counted as valid
        always_ff @(posedge m_axis_aclk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
        end

        assign rd_entry                    = mem_q[rd_ptr_q];
        assign acknowledge[c]              = ack_q;
        assign m_axis_tvalid[c]            = !fifo_empty;
        assign m_axis_tdata[c*BEAT +: BEAT] = fifo_empty ? '0 : rd_entry[BEAT-1:0];
        assign m_axis_tkeep[c*KEEP +: KEEP] = fifo_empty ? '0 : rd_entry[BEAT +: KEEP];
        assign m_axis_tlast[c]             = !fifo_empty && rd_entry[EW-1];
        assign frame_cnt[c*16 +: 16]       = frame_cnt_q;
    end

endmodule

// File: tb/tb_join_recv_pack_xc.sv
// Bench for join_recv_pack_xc: drives four-phase links per channel, keeps a
// beat-level model of packing/framing/flush, and checks every AXIS transfer.
module tb_join_recv_pack_xc;

    localparam int CH    = 4;
    localparam int DW    = 32;
    localparam int PK    = 2;
    localparam int DEPTH = 16;
    localparam int TO    = 16;

    logic         clk = 1'b0;
    logic         areset;
    logic [3:0]   request;
    logic [127:0] din;
    logic [3:0]   ack;
    logic [63:0]  frame_len;
    logic [3:0]   tready;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic [3:0]   tlast;
    logic [3:0]   tvalid;
    logic [63:0]  frame_cnt;

    join_recv_pack_xc #(
        .CHANNEL(CH), .DIN_WIDTH(DW), .PACK(PK), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .m_axis_aclk(clk),
        .m_axis_areset(areset),
        .request(request),
        .din(din),
        .acknowledge(ack),
        .frame_len(frame_len),
        .m_axis_tready(tready),
        .m_axis_tdata(tdata),
        .m_axis_tkeep(tkeep),
        .m_axis_tlast(tlast),
        .m_axis_tvalid(tvalid),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    bit    rnd_en   = 0;

    beat_t       exp_q [4][$];
    logic [31:0] mw [4][PK];
    int          mcnt [4];
    int          mbeat [4];
    int          mlen [4];
    int          mframes [4];
    beat_t       last_pop [4];
    int          pop_cnt [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            exp_q[c].delete();
            mcnt[c] = 0; mbeat[c] = 0; mlen[c] = 0; mframes[c] = 0;
        end
    endtask

    task automatic model_beat(input int ch, input logic [7:0] keep, input logic force_last);
        beat_t b;
        b.data = '0;
        for (int k = 0; k < mcnt[ch]; k++) b.data[k*32 +: 32] = mw[ch][k];
        b.keep = keep;
        if (mbeat[ch] == 0) mlen[ch] = int'(frame_len[ch*16 +: 16]);
        b.last = force_last || (mlen[ch] != 0 && mbeat[ch] == mlen[ch] - 1);
        if (b.last) begin
            mbeat[ch] = 0;
            mframes[ch]++;
        end else if (mlen[ch] != 0) begin
            mbeat[ch]++;
        end
        exp_q[ch].push_back(b);
        mcnt[ch] = 0;
    endtask

    task automatic model_word(input int ch, input logic [31:0] w);
        mw[ch][mcnt[ch]] = w;
        mcnt[ch]++;
        if (mcnt[ch] == PK) model_beat(ch, 8'hFF, 1'b0);
    endtask

    task automatic model_flush(input int ch);
        logic [7:0] keep;
        keep = '0;
        for (int k = 0; k < mcnt[ch]; k++) keep[k*4 +: 4] = 4'hF;
        model_beat(ch, keep, 1'b1);
    endtask

    // ---------------- cycle counter / random ready ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) tready = 4'($urandom);
    end

    // ---------------- compare process ----------------
    initial begin
        logic [3:0] pv;
        logic [3:0] pr;
        beat_t      pb [4];
        pv = '0; pr = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                pv = '0;
            end else begin
                for (int c = 0; c < 4; c++) begin
                    beat_t cur;
                    cur = {tlast[c], tkeep[c*8 +: 8], tdata[c*64 +: 64]};
                    if (pv[c] && !pr[c])
                        chk($sformatf("axis_hold_ch%0d", c), {tvalid[c], cur}, {1'b1, pb[c]});
                    if (tvalid[c] && tready[c]) begin
                        if (exp_q[c].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_beat_ch%0d: got %0h expected none", c, cur);
                        end else begin
                            chk($sformatf("beat_ch%0d", c), cur, exp_q[c].pop_front());
                        end
                        last_pop[c] = cur;
                        pop_cnt[c]++;
                    end
                    pv[c] = tvalid[c];
                    pr[c] = tready[c];
                    pb[c] = cur;
                end
            end
        end
    end

    // ---------------- link drivers ----------------
    task automatic raise_wait(input int ch, input logic [31:0] w, input int budget,
                              output int ack_cyc, output int edges, output bit ok);
        chk($sformatf("ack_low_before_req_ch%0d", ch), ack[ch], 0);
        din[ch*32 +: 32] = w;
        request[ch] = 1'b1;
        ok = 0; ack_cyc = -1; edges = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (ack[ch]) begin
                ok = 1; ack_cyc = cyc; edges = i + 1;
                break;
            end
        end
        if (ok) model_word(ch, w);
        else begin
            checks++; failures++;
            $display("FAIL ack_timeout_ch%0d: got no acknowledge expected acknowledge", ch);
        end
    endtask

    task automatic drop_wait(input int ch);
        int lat;
        request[ch] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (!ack[ch]) begin
                lat = i;
                break;
            end
        end
        chk($sformatf("ack_fall_lat_ch%0d", ch), lat, 3);
    endtask

    task automatic send_word(input int ch, input logic [31:0] w);
        int ac, ed;
        bit ok;
        raise_wait(ch, w, 300, ac, ed, ok);
        drop_wait(ch);
    endtask

    task automatic stream(input int ch, input int n);
        for (int i = 0; i < n; i++) send_word(ch, {4'h5, 4'(ch), 24'(i)});
    endtask

    task automatic wait_valid(input int ch, input int budget, output int vcyc);
        vcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (tvalid[ch]) begin
                vcyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  ac, ed, vc, p0;
        bit  ok, seen;
        logic [31:0] w;

        areset = 1'b1; request = '0; din = '0; frame_len = '0; tready = 4'hF;
        model_reset();
        for (int c = 0; c < 4; c++) pop_cnt[c] = 0;
        step(3);
        chk("rst_ack", ack, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        areset = 1'b0;
        step(2);

        // two words pack into one full beat on channel 0
        send_word(0, 32'h11111111);
        raise_wait(0, 32'h22222222, 50, ac, ed, ok);
        chk("ack_rise_lat_in_3_4", (ed >= 3 && ed <= 4), 1);
        wait_valid(0, 20, vc);
        chk("full_beat_latency", vc - ac, 1);
        drop_wait(0);
        step(2);
        chk("t1_beat", last_pop[0], {1'b0, 8'hFF, 64'h2222222211111111});
        chk("t1_pops", pop_cnt[0], 1);

        // frame_len=3 on channel 1
        frame_len[31:16] = 16'd3;
        for (int i = 0; i < 6; i++) send_word(1, 32'h10000000 + i);
        step(5);
        chk("t2_pops", pop_cnt[1], 3);
        chk("t2_last_beat", last_pop[1], {1'b1, 8'hFF, 64'h1000000510000004});
        chk("t2_frame_cnt1", frame_cnt[31:16], 1);
        chk("t2_frame_cnt_others", {frame_cnt[63:32], frame_cnt[15:0]}, 0);
        chk("t2_others_quiet", {pop_cnt[3], pop_cnt[2], pop_cnt[0]}, {32'd0, 32'd0, 32'd1});

        // single word then idle: flush with partial tkeep
        raise_wait(0, 32'hA5A5A5A5, 50, ac, ed, ok);
        model_flush(0);
        drop_wait(0);
        wait_valid(0, 60, vc);
        chk("flush_latency", vc - ac, 16);
        step(2);
        chk("t3_flush_beat", last_pop[0], {1'b1, 8'h0F, 64'h00000000A5A5A5A5});
        chk("t3_frame_cnt0", frame_cnt[15:0], 1);

        // backpressure on channel 2 until FIFO and packer are both full
        tready[2] = 1'b0;
        for (int i = 0; i < 2*DEPTH + 2; i++) send_word(2, 32'h20000000 + i);
        w = 32'h20000000 + 2*DEPTH + 2;
        chk("t4_no_pop_yet", pop_cnt[2], 0);
        din[95:64] = w;
        request[2] = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (ack[2]) seen = 1;
        end
        chk("t4_stall_no_ack", seen, 0);
        chk("t4_tvalid_held", tvalid[2], 1);
        tready[2] = 1'b1;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (ack[2]) begin ok = 1; break; end
        end
        chk("t4_stalled_ack_completes", ok, 1);
        if (ok) begin
            model_word(2, w);
            model_flush(2);
        end
        drop_wait(2);
        for (int i = 0; i < 200 && pop_cnt[2] < 18; i++) step(1);
        chk("t4_drained_beats", pop_cnt[2], 18);
        chk("t4_queue_empty", exp_q[2].size(), 0);

        // all channels concurrently with random ready
        frame_len = {16'd1, 16'd5, 16'd0, 16'd2};
        rnd_en = 1;
        fork
            stream(0, 12);
            stream(1, 12);
            stream(2, 12);
            stream(3, 12);
        join
        rnd_en = 0;
        tready = 4'hF;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
        end
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("t5_empty_ch%0d", c), exp_q[c].size(), 0);
            chk($sformatf("t5_frame_cnt_ch%0d", c), frame_cnt[c*16 +: 16], mframes[c]);
        end
        chk("t5_frame_cnt_literal", frame_cnt, {16'd6, 16'd2, 16'd1, 16'd4});

        // reset in WAIT_LOW on channel 3 with 5 beats queued and 1 word packed
        frame_len = '0;
        tready[3] = 1'b0;
        for (int i = 0; i < 10; i++) send_word(3, 32'h30000000 + i);
        raise_wait(3, 32'h3000000A, 50, ac, ed, ok);
        areset = 1'b1;
        request[3] = 1'b0;
        step(1);
        chk("t6_ack_after_rst", ack, 0);
        chk("t6_tvalid_after_rst", tvalid, 0);
        chk("t6_frame_cnt_after_rst", frame_cnt, 0);
        model_reset();
        areset = 1'b0;
        tready[3] = 1'b1;
        step(3);
        p0 = pop_cnt[3];
        send_word(3, 32'hCAFE0001);
        send_word(3, 32'hCAFE0002);
        step(4);
        chk("t6_one_new_beat", pop_cnt[3] - p0, 1);
        chk("t6_new_beat", last_pop[3], {1'b0, 8'hFF, 64'hCAFE0002CAFE0001});
        step(30);
        chk("t6_no_stale_beats", pop_cnt[3] - p0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
